stream_checker: RTL and testbench

- Receive-side counterpart of the incrementing 32-bit test stream source.
- Consumes a 32-bit word plus a single-cycle ready strobe, typically after the stream has passed through SDRAM write/readback.
- Checks that successive words increment by exactly 1 (mod 2^32).
- Reports errors, first-failure capture, word count and a stall watchdog to the test controller.

---
 rtl/stream_pkg.sv | 17 +
 rtl/stream_gap_timer.sv | 30 +++
 rtl/stream_checker.sv | 118 +++++++++++
 tb/tb_stream_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the incrementing 32-bit test stream (generator and checker).
package stream_pkg;

  localparam int STREAM_W = 32;
  localparam logic [STREAM_W-1:0] STREAM_INIT = 32'hFAFBFCFD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  function automatic logic [STREAM_W-1:0] nextWord(input logic [STREAM_W-1:0] w);
    return w + 32'd1;
  endfunction

endpackage

// File: rtl/stream_gap_timer.sv
// Saturating count of strobe-free cycles; expired flags the cycle the count reaches TICKS.
module stream_gap_timer #(
  parameter int TICKS = 64
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TICKS);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (!run || kick) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Asserted on the idle cycle whose edge brings the count to LIMIT, so the
  // registered timeout flag in the checker rises on that same edge.
  assign expired = run && !kick && (r_cnt == LIMIT - 16'd1);

endmodule

// File: rtl/stream_checker.sv
// Receive-side checker for the incrementing 32-bit test stream: sequence check,
// first-failure capture, word/error counts and a stall watchdog.
module stream_checker
  import stream_pkg::*;
#(
  parameter logic [STREAM_W-1:0] INIT_VALUE    = STREAM_INIT,
  parameter bit                  SYNC_ANY      = 1'b0,
  parameter int                  TIMEOUT_TICKS = 64,
  parameter int                  ERR_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [STREAM_W-1:0]  s32,
  input  logic                 n32rdy,
  output logic                 synced,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [STREAM_W-1:0]  word_cnt,
  output logic [STREAM_W-1:0]  first_exp,
  output logic [STREAM_W-1:0]  first_got,
  output logic                 timeout
);

  state_t                r_state;
  logic [STREAM_W-1:0]   r_expected;
  logic [STREAM_W-1:0]   r_wordCnt;
  logic [STREAM_W-1:0]   r_firstExp;
  logic [STREAM_W-1:0]   r_firstGot;
  logic [ERR_CNT_W-1:0]  r_errCnt;
  logic                  r_synced;
  logic                  r_err;
  logic                  r_timeout;

  logic                  w_accept;
  logic                  w_mismatch;
  logic                  w_run;
  logic                  w_expired;
  logic [STREAM_W-1:0]   w_refValue;

  // In SYNC the reference is always INIT_VALUE, even if r_expected was left
  // elsewhere by a disable/re-enable; clr always beats a coincident strobe.
  assign w_accept   = en && !clr && n32rdy && (r_state == ST_SYNC || r_state == ST_CHECK);
  assign w_refValue = (r_state == ST_SYNC) ? INIT_VALUE : r_expected;
  assign w_mismatch = w_accept && (s32 != w_refValue) && !(r_state == ST_SYNC && SYNC_ANY);
  assign w_run      = en && !clr && (r_state == ST_CHECK);

  stream_gap_timer #(
    .TICKS (TIMEOUT_TICKS)
  ) u_gap (
    .clk     (clk),
    .n_rst   (n_rst),
    .run     (w_run),
    .kick    (n32rdy),
    .expired (w_expired)
  );

  // Resync on every accepted word: the next expected value always follows
  // what was actually received, so one bad word costs two mismatches.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_expected <= INIT_VALUE;
      r_wordCnt  <= '0;
      r_firstExp <= '0;
      r_firstGot <= '0;
      r_errCnt   <= '0;
      r_synced   <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (clr) begin
      r_state    <= en ? ST_SYNC : ST_IDLE;
      r_expected <= INIT_VALUE;
      r_wordCnt  <= '0;
      r_firstExp <= '0;
      r_firstGot <= '0;
      r_errCnt   <= '0;
      r_synced   <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (!en) begin
      r_state <= ST_IDLE;
    end else begin
      if (r_state == ST_IDLE) begin
        r_state <= ST_SYNC;
      end
      if (w_accept) begin
        r_expected <= nextWord(s32);
        r_wordCnt  <= r_wordCnt + 32'd1;
        r_synced   <= 1'b1;
        r_state    <= ST_CHECK;
      end
      if (w_mismatch) begin
        r_err <= 1'b1;
        if (r_errCnt != '1) begin
          r_errCnt <= r_errCnt + ERR_CNT_W'(1);
        end
        if (!r_err) begin
          r_firstExp <= w_refValue;
          r_firstGot <= s32;
        end
      end
      if (w_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign synced    = r_synced;
  assign err       = r_err;
  assign err_cnt   = r_errCnt;
  assign word_cnt  = r_wordCnt;
  assign first_exp = r_firstExp;
  assign first_got = r_firstGot;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: three instances (default, SYNC_ANY=1,
// ERR_CNT_W=4) share one stimulus stream.
module tb_stream_checker;

  logic        clk;
  logic        n_rst;
  logic        en;
  logic        clr;
  logic [31:0] s32;
  logic        n32rdy;

  logic        synced0, err0, timeout0;
  logic [15:0] errCnt0;
  logic [31:0] wordCnt0, firstExp0, firstGot0;

  logic        synced1, err1, timeout1;
  logic [15:0] errCnt1;
  logic [31:0] wordCnt1, firstExp1, firstGot1;

  logic        synced2, err2, timeout2;
  logic [3:0]  errCnt2;
  logic [31:0] wordCnt2, firstExp2, firstGot2;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic        clr;
    logic        rdy;
    logic [31:0] data;
    logic        expSynced;
    logic [15:0] expErrCnt;
    logic [31:0] expWordCnt;
    logic [31:0] expFirstExp;
    logic [31:0] expFirstGot;
  } vec_t;

  vec_t vecs[15];

  stream_checker dut0 (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .s32(s32), .n32rdy(n32rdy),
    .synced(synced0), .err(err0), .err_cnt(errCnt0), .word_cnt(wordCnt0),
    .first_exp(firstExp0), .first_got(firstGot0), .timeout(timeout0)
  );

  stream_checker #(.SYNC_ANY(1'b1)) dut1 (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .s32(s32), .n32rdy(n32rdy),
    .synced(synced1), .err(err1), .err_cnt(errCnt1), .word_cnt(wordCnt1),
    .first_exp(firstExp1), .first_got(firstGot1), .timeout(timeout1)
  );

  stream_checker #(.ERR_CNT_W(4)) dut2 (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .s32(s32), .n32rdy(n32rdy),
    .synced(synced2), .err(err2), .err_cnt(errCnt2), .word_cnt(wordCnt2),
    .first_exp(firstExp2), .first_got(firstGot2), .timeout(timeout2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic c, input logic r, input logic [31:0] d);
    clr    = c;
    n32rdy = r;
    s32    = d;
    @(posedge clk);
    #1;
    clr    = 1'b0;
    n32rdy = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 16'd0, 32'd0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'hFAFBFCFD, 1'b1, 16'd0, 32'd1, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'hFAFBFCFE, 1'b1, 16'd0, 32'd2, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'hFAFBFCFF, 1'b1, 16'd0, 32'd3, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h12345678, 1'b1, 16'd1, 32'd4, 32'hFAFBFD00, 32'h12345678};
    vecs[5]  = '{1'b0, 1'b1, 32'hFAFBFD01, 1'b1, 16'd2, 32'd5, 32'hFAFBFD00, 32'h12345678};
    vecs[6]  = '{1'b0, 1'b1, 32'hFAFBFD02, 1'b1, 16'd2, 32'd6, 32'hFAFBFD00, 32'h12345678};
    vecs[7]  = '{1'b0, 1'b1, 32'hFAFBFD03, 1'b1, 16'd2, 32'd7, 32'hFAFBFD00, 32'h12345678};
    vecs[8]  = '{1'b0, 1'b1, 32'hFAFBFD04, 1'b1, 16'd2, 32'd8, 32'hFAFBFD00, 32'h12345678};
    vecs[9]  = '{1'b1, 1'b1, 32'hFAFBFCFD, 1'b0, 16'd0, 32'd0, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'hFAFBFCFD, 1'b1, 16'd0, 32'd1, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'hFAFBFCFE, 1'b1, 16'd0, 32'd2, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'hFAFBFCFF, 1'b1, 16'd0, 32'd3, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 1'b1, 32'hFAFBFD01, 1'b1, 16'd1, 32'd4, 32'hFAFBFD00, 32'hFAFBFD01};
    vecs[14] = '{1'b0, 1'b1, 32'hFAFBFD02, 1'b1, 16'd1, 32'd5, 32'hFAFBFD00, 32'hFAFBFD01};

    n_rst  = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    n32rdy = 1'b0;
    s32    = 32'h0;
    idleCycles(2);
    checkOutput("reset synced",   32'(synced0),  32'd0);
    checkOutput("reset err",      32'(err0),     32'd0);
    checkOutput("reset errCnt",   32'(errCnt0),  32'd0);
    checkOutput("reset wordCnt",  wordCnt0,      32'd0);
    checkOutput("reset firstExp", firstExp0,     32'd0);
    checkOutput("reset timeout",  32'(timeout0), 32'd0);

    n_rst = 1'b1;
    en    = 1'b1;
    idleCycles(2);

    // Clean stream, one strobe every 8 cycles
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hFAFBFCFD + 32'(i));
      if (i == 0) checkOutput("clean synced first", 32'(synced0), 32'd1);
      idleCycles(7);
    end
    checkOutput("clean wordCnt",  wordCnt0,      32'd8);
    checkOutput("clean errCnt",   32'(errCnt0),  32'd0);
    checkOutput("clean err",      32'(err0),     32'd0);
    checkOutput("clean timeout",  32'(timeout0), 32'd0);
    checkOutput("clean any errCnt", 32'(errCnt1), 32'd0);
    checkOutput("clean any wordCnt", wordCnt1,    32'd8);

    // Corrupted word, clr-with-strobe, dropped word
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].rdy, vecs[i].data);
      checkOutput($sformatf("v%0d synced", i),   32'(synced0), 32'(vecs[i].expSynced));
      checkOutput($sformatf("v%0d errCnt", i),   32'(errCnt0), 32'(vecs[i].expErrCnt));
      checkOutput($sformatf("v%0d wordCnt", i),  wordCnt0,     vecs[i].expWordCnt);
      checkOutput($sformatf("v%0d firstExp", i), firstExp0,    vecs[i].expFirstExp);
      checkOutput($sformatf("v%0d firstGot", i), firstGot0,    vecs[i].expFirstGot);
      checkOutput($sformatf("v%0d err", i),      32'(err0),    32'(vecs[i].expErrCnt != 0));
      idleCycles(3);
    end

    // Wraparound, back-to-back strobes
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFE);
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF);
    applyStimulus(1'b0, 1'b1, 32'h00000000);
    applyStimulus(1'b0, 1'b1, 32'h00000001);
    checkOutput("wrap any errCnt",  32'(errCnt1),  32'd0);
    checkOutput("wrap any wordCnt", wordCnt1,      32'd4);
    checkOutput("wrap any synced",  32'(synced1),  32'd1);
    checkOutput("wrap init errCnt", 32'(errCnt0),  32'd1);
    checkOutput("wrap init firstExp", firstExp0,   32'hFAFBFCFD);
    checkOutput("wrap init firstGot", firstGot0,   32'hFFFFFFFE);

    // Gap watchdog boundary
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hFAFBFCFD);
    idleCycles(63);
    checkOutput("gap63 before strobe", 32'(timeout0), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hFAFBFCFE);
    checkOutput("gap63 timeout", 32'(timeout0), 32'd0);
    idleCycles(64);
    checkOutput("gap64 timeout", 32'(timeout0), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'hFAFBFCFF);
    applyStimulus(1'b0, 1'b1, 32'hFAFBFD00);
    checkOutput("gap sticky timeout", 32'(timeout0), 32'd1);
    checkOutput("gap errCnt",         32'(errCnt0),  32'd0);
    checkOutput("gap wordCnt",        wordCnt0,      32'd4);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("gap clr timeout", 32'(timeout0), 32'd0);

    // Saturating 4-bit error counter, then asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h10000000 + 32'(2 * i));
    end
    checkOutput("sat errCnt",   32'(errCnt2), 32'hF);
    checkOutput("sat wordCnt",  wordCnt2,     32'd20);
    checkOutput("sat firstExp", firstExp2,    32'hFAFBFCFD);
    checkOutput("sat firstGot", firstGot2,    32'h10000000);
    checkOutput("sat err",      32'(err2),    32'd1);

    n32rdy = 1'b1;
    s32    = 32'h10000028;
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("async errCnt",   32'(errCnt2),  32'd0);
    checkOutput("async wordCnt",  wordCnt2,      32'd0);
    checkOutput("async err",      32'(err2),     32'd0);
    checkOutput("async firstExp", firstExp2,     32'd0);
    checkOutput("async firstGot", firstGot2,     32'd0);
    checkOutput("async synced",   32'(synced2),  32'd0);
    checkOutput("async dut0 wordCnt", wordCnt0,  32'd0);
    n32rdy = 1'b0;
    idleCycles(2);
    checkOutput("held reset wordCnt", wordCnt2, 32'd0);
    n_rst = 1'b1;
    idleCycles(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
